// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IFU)
// and load/store (LSU), with a response timeout so a dead slave cannot hang the core.
module riscv_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic              ifu_rsp_err,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [2:0]        lsu_memop,
  output logic              lsu_rsp_valid,
  output logic              lsu_rsp_err,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_memop,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);
  localparam logic [2:0]  MEMOP_WORD = 3'b010;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        memop_q, memop_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              grant_lsu;
  logic              rsp_fire;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    memop_d       = memop_q;
    cnt_d         = cnt_q;
    grant_lsu     = 1'b0;
    rsp_fire      = 1'b0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    ifu_rdata     = '0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_err   = 1'b0;
    lsu_rdata     = '0;

    unique case (state_q)
      IDLE: begin
        if (ifu_req_valid || lsu_req_valid) begin
          // On a tie the master that did not win last time gets the port.
          grant_lsu     = lsu_req_valid && (!ifu_req_valid || !last_grant_q);
          ifu_req_ready = !grant_lsu;
          lsu_req_ready = grant_lsu;
          owner_d       = grant_lsu;
          last_grant_d  = grant_lsu;
          state_d       = REQ;
          if (grant_lsu) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            memop_d = lsu_memop;
          end else begin
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            memop_d = MEMOP_WORD;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A real response in the timeout cycle wins over the error.
        rsp_fire = mem_rsp_valid || (cnt_q == TIMEOUT_C);
        if (rsp_fire) begin
          state_d = IDLE;
          if (owner_q) begin
            lsu_rsp_valid = 1'b1;
            lsu_rsp_err   = !mem_rsp_valid;
            lsu_rdata     = mem_rsp_valid ? mem_rdata : '0;
          end else begin
            ifu_rsp_valid = 1'b1;
            ifu_rsp_err   = !mem_rsp_valid;
            ifu_rdata     = mem_rsp_valid ? mem_rdata : '0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      memop_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      memop_q      <= memop_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_memop     = memop_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: table of transactions plus
// hand-written timeout and reset sequences, with a response scoreboard.
module tb_riscv_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [2:0]  lsu_memop;
  logic        lsu_rsp_valid;
  logic        lsu_rsp_err;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_memop;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        busy;

  riscv_mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_addr     (ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_err  (ifu_rsp_err),
    .ifu_rdata    (ifu_rdata),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_addr     (lsu_addr),
    .lsu_wen      (lsu_wen),
    .lsu_wdata    (lsu_wdata),
    .lsu_memop    (lsu_memop),
    .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_err  (lsu_rsp_err),
    .lsu_rdata    (lsu_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_memop    (mem_memop),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  typedef struct {
    logic        pre_reset;
    logic        ifu_v;
    logic [31:0] ifu_addr;
    logic        lsu_v;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [2:0]  lsu_memop;
    logic        exp_lsu;
    logic [31:0] exp_addr;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic [2:0]  exp_memop;
    logic [31:0] mem_rdata;
    int          stall;
    int          delay;
  } vec_t;

  typedef struct {
    logic        lsu;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   compared;
  int   mismatched;
  vec_t vecs[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutputBit(input string name, input logic act, input logic req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Any response strobe must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (ifu_rsp_valid || lsu_rsp_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_owner", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, e.lsu ? 32'd1 : 32'd2);
        checkOutputBit("rsp_err", e.lsu ? lsu_rsp_err : ifu_rsp_err, e.err);
        checkOutput("rsp_rdata", e.lsu ? lsu_rdata : ifu_rdata, e.rdata);
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    if (v.pre_reset) pulseReset();
    ifu_req_valid = v.ifu_v;
    ifu_addr      = v.ifu_addr;
    lsu_req_valid = v.lsu_v;
    lsu_addr      = v.lsu_addr;
    lsu_wen       = v.lsu_wen;
    lsu_wdata     = v.lsu_wdata;
    lsu_memop     = v.lsu_memop;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    checkOutputBit("busy_idle", busy, 1'b0);
    checkOutputBit("ifu_req_ready", ifu_req_ready, !v.exp_lsu);
    checkOutputBit("lsu_req_ready", lsu_req_ready, v.exp_lsu);
    checkOutputBit("mem_valid_idle", mem_req_valid, 1'b0);
    sb.push_back('{lsu: v.exp_lsu, err: 1'b0, rdata: v.mem_rdata});
    tick();
    if (v.exp_lsu) lsu_req_valid = 1'b0;
    else ifu_req_valid = 1'b0;
    for (int k = 0; k <= v.stall; k++) begin
      mem_req_ready = (k == v.stall);
      @(negedge clk);
      checkOutputBit("mem_req_valid", mem_req_valid, 1'b1);
      checkOutput("mem_addr", mem_addr, v.exp_addr);
      checkOutputBit("mem_wen", mem_wen, v.exp_wen);
      checkOutput("mem_wdata", mem_wdata, v.exp_wdata);
      checkOutput("mem_memop", 32'(mem_memop), 32'(v.exp_memop));
      checkOutputBit("busy_req", busy, 1'b1);
      checkOutput("ready_in_req", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
      tick();
    end
    mem_req_ready = 1'b0;
    for (int d = 0; d <= v.delay; d++) begin
      mem_rsp_valid = (d == v.delay);
      mem_rdata     = (d == v.delay) ? v.mem_rdata : (32'h5A5A_0000 | 32'(d));
      @(negedge clk);
      checkOutputBit("mem_valid_wait", mem_req_valid, 1'b0);
      checkOutputBit("busy_wait", busy, 1'b1);
      if (d == v.delay) begin
        checkOutputBit("owner_rsp_valid", v.exp_lsu ? lsu_rsp_valid : ifu_rsp_valid, 1'b1);
      end else begin
        checkOutput("early_rsp", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        checkOutput("rdata_idle_ifu", ifu_rdata, 32'd0);
        checkOutput("rdata_idle_lsu", lsu_rdata, 32'd0);
      end
      tick();
    end
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b1;
    ifu_req_valid = 1'b0;
    ifu_addr      = 32'd0;
    lsu_req_valid = 1'b0;
    lsu_addr      = 32'd0;
    lsu_wen       = 1'b0;
    lsu_wdata     = 32'd0;
    lsu_memop     = 3'd0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'd0;

    vecs[0] = '{1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000,
                1'b0, 32'h8000_0000, 1'b0, 32'h0, 3'b010, 32'h0000_0413, 0, 1};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 3'b010,
                1'b1, 32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 3'b010, 32'h0, 4, 0};
    vecs[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_2004, 1'b0, 32'h0, 3'b101,
                1'b1, 32'h8000_2004, 1'b0, 32'h0, 3'b101, 32'hCAFE_F00D, 1, 3};
    vecs[3] = '{1'b0, 1'b1, 32'h8000_0010, 1'b0, 32'h8000_2008, 1'b1, 32'h7777_7777, 3'b001,
                1'b0, 32'h8000_0010, 1'b0, 32'h0, 3'b010, 32'h0010_0093, 2, 0};
    vecs[4] = '{1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_1000, 1'b0, 32'h1111_1111, 3'b100,
                1'b0, 32'h8000_0004, 1'b0, 32'h0, 3'b010, 32'h00A0_0513, 0, 1};
    vecs[5] = '{1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_1000, 1'b0, 32'h1111_1111, 3'b100,
                1'b1, 32'h8000_1000, 1'b0, 32'h1111_1111, 3'b100, 32'h0000_00FF, 0, 0};
    vecs[6] = '{1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_1004, 1'b1, 32'h55AA_55AA, 3'b001,
                1'b0, 32'h8000_0008, 1'b0, 32'h0, 3'b010, 32'h0000_0013, 1, 2};
    vecs[7] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_1004, 1'b1, 32'h55AA_55AA, 3'b001,
                1'b1, 32'h8000_1004, 1'b1, 32'h55AA_55AA, 3'b001, 32'h0, 0, 0};

    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutputBit("rst_busy", busy, 1'b0);
    checkOutputBit("rst_mem_valid", mem_req_valid, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_memop", 32'(mem_memop), 32'd0);
    checkOutput("rst_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
    tick();

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Timeout: LSU load, memory accepts but never answers.
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_3000;
    lsu_wen       = 1'b0;
    lsu_wdata     = 32'd0;
    lsu_memop     = 3'b010;
    @(negedge clk);
    checkOutputBit("to_lsu_ready", lsu_req_ready, 1'b1);
    sb.push_back('{lsu: 1'b1, err: 1'b1, rdata: 32'd0});
    tick();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hDEAD_0001;
    @(negedge clk);
    checkOutputBit("to_mem_valid", mem_req_valid, 1'b1);
    checkOutput("to_stray_in_req", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    for (int w = 0; w <= 8; w++) begin
      mem_rdata = 32'hA5A5_0000 | 32'(w);
      @(negedge clk);
      checkOutputBit("to_strobe", lsu_rsp_valid, (w == 8));
      checkOutputBit("to_err", lsu_rsp_err, (w == 8));
      tick();
    end
    @(negedge clk);
    checkOutputBit("to_back_idle", busy, 1'b0);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0BAD_0BAD;
    @(negedge clk);
    checkOutput("to_late_rsp", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
    tick();
    mem_rsp_valid = 1'b0;

    // Reset while waiting for an IFU response abandons the transaction.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0020;
    @(negedge clk);
    checkOutputBit("mr_ifu_ready", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    checkOutputBit("mr_mem_valid", mem_req_valid, 1'b1);
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    checkOutputBit("mr_busy_wait", busy, 1'b1);
    tick();
    pulseReset();
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h1357_2468;
    @(negedge clk);
    checkOutputBit("mr_busy", busy, 1'b0);
    checkOutputBit("mr_mem_valid0", mem_req_valid, 1'b0);
    checkOutput("mr_mem_addr", mem_addr, 32'd0);
    checkOutputBit("mr_mem_wen", mem_wen, 1'b0);
    checkOutput("mr_mem_wdata", mem_wdata, 32'd0);
    checkOutput("mr_mem_memop", 32'(mem_memop), 32'd0);
    checkOutput("mr_rsp", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
    checkOutput("mr_rdata", ifu_rdata | lsu_rdata, 32'd0);
    tick();
    mem_rsp_valid = 1'b0;
    applyStimulus('{1'b0, 1'b1, 32'h8000_0024, 1'b1, 32'h8000_4000, 1'b0, 32'h0, 3'b000,
                    1'b0, 32'h8000_0024, 1'b0, 32'h0, 3'b010, 32'h0000_0073, 0, 0});
    applyStimulus('{1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_4000, 1'b0, 32'h0, 3'b000,
                    1'b1, 32'h8000_4000, 1'b0, 32'h0, 3'b000, 32'h2468_ACE0, 0, 1});

    @(negedge clk);
    checkOutputBit("end_idle", busy, 1'b0);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
